i2c_byte_ctrl: RTL and testbench
================================

Name: i2c_byte_ctrl

Overview:
Byte-level master sequencer for the I2C bit PHY. It accepts one command per valid/ready handshake: optional START, optional write-byte or read-byte, optional STOP. It expands each command into PHY bit requests, shifts data MSB-first, collects or drives the ACK bit, and returns one response per command. It sits between the register/host layer and the PHY; all bus timing stays in the PHY.

Parameters:
TIMEOUT_CYCLES, 65535, clk cycles one PHY bit operation may take before abort (only with I2C_CTRL_TIMEOUT_EN).

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller accepts command this cycle
cmd_start  input  1  issue START (repeated START if bus already held)
cmd_write  input  1  write cmd_data, sample ACK
cmd_read  input  1  read byte, then send ACK/NACK
cmd_stop  input  1  issue STOP after the byte phase
cmd_nack  input  1  ACK bit value driven after a read (1 = NACK)
cmd_data  input  8  byte to write
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_data  output  8  byte read (0 for non-read commands)
rsp_nack  output  1  ACK bit sampled after a write (0 otherwise)
rsp_err  output  1  illegal command or timeout
phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit  output  1 each  PHY bit requests
phy_tx_data  output  1  bit to write
phy_release_bus  output  1  force PHY idle
phy_state  input  5  PHY state (0 = IDLE, 1 = ACTIVE)
phy_rx_data  input  1  last bit read by PHY
bus_control  input  1  PHY holds the bus

Behaviour:
- Reset: cmd_ready=0 for the reset cycle, then 1 in S_IDLE. All phy_* requests 0, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0, bit counter=0.
- PHY handshake for each bit operation:
  - ISSUE: hold exactly one request high until phy_state is neither 0 nor 1, then drop it.
  - WAIT: wait until phy_state returns to 1 (START/bit) or 0 (STOP).
  - Requests are mutually exclusive and never asserted outside ISSUE.
- States: S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_RESP.
- S_IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields and go to the first applicable phase in this order: START, byte, STOP. cmd_ready is 0 in every state other than S_IDLE.
- Illegal command: go directly to S_RESP with rsp_err=1 and no PHY activity when either holds:
  - cmd_write and cmd_read both 1;
  - a write or read with no cmd_start while bus_control=0.
- Empty command (no fields set) goes to S_RESP with no bus activity and all response bits 0.
- S_WBIT: 8 write_bit operations, phy_tx_data = shift[7], shift left after each. Bit counter counts 7 down to 0. Then S_WACK.
- S_WACK: one read_bit operation; rsp_nack = phy_rx_data sampled at WAIT exit.
- S_RBIT: 8 read_bit operations; shift in phy_rx_data at each WAIT exit, LSB side. Then S_RACK.
- S_RACK: one write_bit with phy_tx_data = latched cmd_nack.
- S_STOP: executed only when cmd_stop=1 and bus_control=1; otherwise skipped.
- S_RESP: rsp_valid=1 with stable fields until rsp_ready; then rsp_valid=0 and return to S_IDLE. The earliest next acceptance is the following cycle.
- A NACK after a write does not abort: STOP still runs if requested.
- Reset mid-operation returns to reset values immediately. Reset does not pulse phy_release_bus; the PHY reset handles the bus.

Optional Feature:
I2C_CTRL_TIMEOUT_EN:
- Defined: a 16-bit watchdog loads TIMEOUT_CYCLES on entry to each ISSUE phase and decrements every cycle in ISSUE/WAIT. On reaching 0, assert phy_release_bus for exactly one cycle, drop all requests, and go to S_RESP with rsp_err=1 and rsp_data=0.
- Not defined: no watchdog; the controller waits indefinitely (clock stretching unbounded); phy_release_bus is tied 0.

Test Plan:
1. START+write 0xA5+STOP, PHY model ACKs (SDA=0) -> phy_write_bit sequence carries 1,0,1,0,0,1,0,1; one read_bit; STOP issued; rsp_valid with rsp_nack=0, rsp_err=0; phy_state ends at 0.
2. START+write 0x3C, slave NACKs, no STOP -> rsp_nack=1; bus_control stays 1; next command write 0x00 without START is accepted, not flagged as an error.
3. Read with cmd_nack=1+STOP on a held bus, slave drives 0x96 -> rsp_data=0x96; the 9th PHY op is write_bit with phy_tx_data=1; STOP issued.
4. cmd_write=cmd_read=1, and separately write without START while bus idle -> rsp_err=1 within 2 cycles; no phy_* request ever asserted.
5. Hold rsp_ready=0 for 20 cycles after a response -> rsp_valid and fields stable; cmd_ready=0 throughout; on rsp_ready=1, cmd_ready=1 the next cycle.
6. With I2C_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=100, PHY stuck in a non-idle state -> phy_release_bus=1 for one cycle at cycle 100 after ISSUE entry; rsp_err=1. Also assert rst mid-byte -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/i2c_byte_ctrl.sv
// i2c_byte_ctrl: byte-level I2C master sequencer sitting on top of the bit PHY.
// Each accepted command expands into START / 8 data bits + ACK / STOP bit
// requests; all bus timing lives in the PHY.
// Optional watchdog: define I2C_CTRL_TIMEOUT_EN to abort any PHY bit operation
// that takes longer than TIMEOUT_CYCLES clocks.
//
// state   | meaning
// S_IDLE  | ready for a command
// S_START | START / repeated START bit operation
// S_WBIT  | writing data bits, MSB first
// S_WACK  | reading the slave ACK after a write
// S_RBIT  | reading data bits, MSB first
// S_RACK  | driving ACK/NACK after a read
// S_STOP  | STOP bit operation
// S_RESP  | holding the response until consumed
module i2c_byte_ctrl #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_write,
    input  logic       cmd_read,
    input  logic       cmd_stop,
    input  logic       cmd_nack,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_err,
    output logic       phy_start_bit,
    output logic       phy_stop_bit,
    output logic       phy_write_bit,
    output logic       phy_read_bit,
    output logic       phy_tx_data,
    output logic       phy_release_bus,
    input  logic [4:0] phy_state,
    input  logic       phy_rx_data,
    input  logic       bus_control
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WBIT, S_WACK, S_RBIT, S_RACK, S_STOP, S_RESP
    } state_t;

    state_t     r_state, w_nxt_state;
    logic       r_wait, w_nxt_wait;     // 0 = ISSUE phase, 1 = WAIT phase
    logic [2:0] r_cnt;
    logic [7:0] r_shift;
    logic       r_write, r_read, r_stop, r_nack;
    logic [7:0] r_rsp_data;
    logic       r_rsp_nack, r_rsp_err;
    logic       w_is_op, w_busy_seen, w_op_done, w_illegal, w_issue;
    logic       w_timeout, w_release;

    // STOP only makes sense while we actually hold the bus
    function automatic state_t after_byte(input logic stop, input logic held);
        return (stop && held) ? S_STOP : S_RESP;
    endfunction

    assign w_is_op     = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_busy_seen = (phy_state != 5'd0) && (phy_state != 5'd1);
    assign w_op_done   = w_is_op && r_wait &&
                         ((r_state == S_STOP) ? (phy_state == 5'd0) : (phy_state == 5'd1));
    assign w_illegal   = (cmd_write && cmd_read) ||
                         ((cmd_write || cmd_read) && !cmd_start && !bus_control);

`ifdef I2C_CTRL_TIMEOUT_EN
    logic [15:0] r_tmo;
    logic        r_release;
    logic        w_tmo_load;

    assign w_timeout  = w_is_op && (r_tmo == 16'd1);
    assign w_tmo_load = (w_nxt_state != S_IDLE) && (w_nxt_state != S_RESP) &&
                        !w_nxt_wait && !(w_is_op && !r_wait);
    assign w_release  = r_release;

    // watchdog: reload on every ISSUE entry, count down while a bit op is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo     <= 16'd0;
            r_release <= 1'b0;
        end else begin
            r_release <= w_timeout;
            if (w_tmo_load)
                r_tmo <= 16'(TIMEOUT_CYCLES);
            else if (w_is_op && (r_tmo != 16'd0))
                r_tmo <= r_tmo - 16'd1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_timeout    = 1'b0;
    assign w_release    = 1'b0;
`endif

    // state and phase register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_wait  <= w_nxt_wait;
        end
    end

    // next-state sequencing: command decode, ISSUE/WAIT handshake, phase order
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_wait  = r_wait;
        case (r_state)
            S_IDLE: begin
                w_nxt_wait = 1'b0;
                if (cmd_valid) begin
                    if (w_illegal)      w_nxt_state = S_RESP;
                    else if (cmd_start) w_nxt_state = S_START;
                    else if (cmd_write) w_nxt_state = S_WBIT;
                    else if (cmd_read)  w_nxt_state = S_RBIT;
                    else                w_nxt_state = after_byte(cmd_stop, bus_control);
                end
            end
            S_RESP: begin
                w_nxt_wait = 1'b0;
                if (rsp_ready) w_nxt_state = S_IDLE;
            end
            default: begin
                if (w_timeout) begin
                    w_nxt_state = S_RESP;
                    w_nxt_wait  = 1'b0;
                end else if (!r_wait) begin
                    if (w_busy_seen) w_nxt_wait = 1'b1;
                end else if (w_op_done) begin
                    w_nxt_wait = 1'b0;
                    case (r_state)
                        S_START: begin
                            if (r_write)     w_nxt_state = S_WBIT;
                            else if (r_read) w_nxt_state = S_RBIT;
                            else             w_nxt_state = after_byte(r_stop, bus_control);
                        end
                        S_WBIT:  if (r_cnt == 3'd0) w_nxt_state = S_WACK;
                        S_RBIT:  if (r_cnt == 3'd0) w_nxt_state = S_RACK;
                        S_WACK,
                        S_RACK:  w_nxt_state = after_byte(r_stop, bus_control);
                        default: w_nxt_state = S_RESP;
                    endcase
                end
            end
        endcase
    end

    // command latch, shift/count datapath and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_read     <= 1'b0;
            r_stop     <= 1'b0;
            r_nack     <= 1'b0;
            r_shift    <= 8'd0;
            r_cnt      <= 3'd0;
            r_rsp_data <= 8'd0;
            r_rsp_nack <= 1'b0;
            r_rsp_err  <= 1'b0;
        end else if ((r_state == S_IDLE) && cmd_valid) begin
            r_write    <= cmd_write;
            r_read     <= cmd_read;
            r_stop     <= cmd_stop;
            r_nack     <= cmd_nack;
            r_shift    <= cmd_data;
            r_cnt      <= 3'd7;
            r_rsp_data <= 8'd0;
            r_rsp_nack <= 1'b0;
            r_rsp_err  <= w_illegal;
        end else if (w_timeout) begin
            r_rsp_err  <= 1'b1;
            r_rsp_data <= 8'd0;
        end else if (w_op_done) begin
            case (r_state)
                S_WBIT: begin
                    r_shift <= {r_shift[6:0], 1'b0};
                    if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                end
                S_WACK: r_rsp_nack <= phy_rx_data;
                S_RBIT: begin
                    r_shift <= {r_shift[6:0], phy_rx_data};
                    if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                    else               r_rsp_data <= {r_shift[6:0], phy_rx_data};
                end
                default: ;
            endcase
        end
    end

    assign w_issue         = !r_wait && !rst;
    assign cmd_ready       = (r_state == S_IDLE) && !rst;
    assign phy_start_bit   = w_issue && (r_state == S_START);
    assign phy_stop_bit    = w_issue && (r_state == S_STOP);
    assign phy_write_bit   = w_issue && ((r_state == S_WBIT) || (r_state == S_RACK));
    assign phy_read_bit    = w_issue && ((r_state == S_RBIT) || (r_state == S_WACK));
    assign phy_tx_data     = (r_state == S_RACK) ? r_nack :
                             (r_state == S_WBIT) ? r_shift[7] : 1'b0;
    assign phy_release_bus = w_release;
    assign rsp_valid       = (r_state == S_RESP);
    assign rsp_data        = r_rsp_data;
    assign rsp_nack        = r_rsp_nack;
    assign rsp_err         = r_rsp_err;
endmodule

// File: tb/tb_i2c_byte_ctrl.sv
// Self-checking bench for i2c_byte_ctrl: behavioural PHY/slave model plus a
// command-level reference that lists the expected PHY operations.
module tb_i2c_byte_ctrl;
    localparam int OP_S = 0, OP_P = 1, OP_W0 = 2, OP_W1 = 3, OP_R = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 0, cmd_start = 0, cmd_write = 0, cmd_read = 0;
    logic       cmd_stop = 0, cmd_nack = 0, rsp_ready = 0;
    logic [7:0] cmd_data = 8'd0;
    logic       cmd_ready, rsp_valid, rsp_nack, rsp_err;
    logic [7:0] rsp_data;
    logic       phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit;
    logic       phy_tx_data, phy_release_bus;
    logic [4:0] phy_state = 5'd0;
    logic       phy_rx_data = 1'b0;
    logic       bus_control = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // PHY model state (written only by the model process)
    int op_q[$];
    int rd_idx = 0, busy_cnt = 0, viol = 0, rel_seen = 0, cur_op = 0, m_nreq = 0;
    // stimulus owned by the test process
    bit slave_bits[$];
    bit stuck = 0;
    // reference model
    int         exp_ops[$];
    logic [7:0] exp_data;
    logic       exp_nack, exp_err;
    bit         ref_bus = 0;

    i2c_byte_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_write(cmd_write), .cmd_read(cmd_read),
        .cmd_stop(cmd_stop), .cmd_nack(cmd_nack), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_nack(rsp_nack), .rsp_err(rsp_err),
        .phy_start_bit(phy_start_bit), .phy_stop_bit(phy_stop_bit),
        .phy_write_bit(phy_write_bit), .phy_read_bit(phy_read_bit),
        .phy_tx_data(phy_tx_data), .phy_release_bus(phy_release_bus),
        .phy_state(phy_state), .phy_rx_data(phy_rx_data), .bus_control(bus_control)
    );

    always #5 clk = ~clk;

    // behavioural PHY + slave: random-length bit operations, logs every request
    always @(posedge clk) begin
        #2;
        m_nreq = int'(phy_start_bit) + int'(phy_stop_bit) + int'(phy_write_bit) + int'(phy_read_bit);
        if (rst) begin
            phy_state = 5'd0; bus_control = 1'b0; busy_cnt = 0; phy_rx_data = 1'b0;
        end else if (phy_release_bus) begin
            rel_seen++;
            phy_state = 5'd0; bus_control = 1'b0; busy_cnt = 0;
        end else if (busy_cnt > 0) begin
            if (m_nreq != 0) viol++;
            if (!stuck) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    phy_state = (cur_op == OP_P) ? 5'd0 : 5'd1;
                    if (cur_op == OP_S) bus_control = 1'b1;
                    if (cur_op == OP_P) bus_control = 1'b0;
                    if (cur_op == OP_R) begin
                        phy_rx_data = (rd_idx < slave_bits.size()) ? slave_bits[rd_idx] : 1'b1;
                        rd_idx++;
                    end
                end
            end
        end else if (m_nreq > 1) begin
            viol++;
        end else if (m_nreq == 1) begin
            if (phy_start_bit)      cur_op = OP_S;
            else if (phy_stop_bit)  cur_op = OP_P;
            else if (phy_write_bit) cur_op = phy_tx_data ? OP_W1 : OP_W0;
            else                    cur_op = OP_R;
            op_q.push_back(cur_op);
            busy_cnt  = $urandom_range(1, 3);
            phy_state = 5'($urandom_range(2, 31));
        end
    end

    // expected PHY operations and response for one command, from the command rules
    task automatic ref_cmd(input bit s, input bit w, input bit r, input bit p, input bit n,
                           input logic [7:0] d, input bit ack, input logic [7:0] sbyte);
        exp_ops.delete();
        exp_data = 8'd0;
        exp_nack = 1'b0;
        exp_err  = (w && r) || ((w || r) && !s && !ref_bus);
        if (exp_err) return;
        if (s) begin exp_ops.push_back(OP_S); ref_bus = 1; end
        if (w) begin
            for (int i = 7; i >= 0; i--) exp_ops.push_back(d[i] ? OP_W1 : OP_W0);
            exp_ops.push_back(OP_R);
            slave_bits.push_back(ack);
            exp_nack = ack;
        end
        if (r) begin
            for (int i = 7; i >= 0; i--) begin
                exp_ops.push_back(OP_R);
                slave_bits.push_back(sbyte[i]);
            end
            exp_ops.push_back(n ? OP_W1 : OP_W0);
            exp_data = sbyte;
        end
        if (p && ref_bus) begin exp_ops.push_back(OP_P); ref_bus = 0; end
    endtask

    // -1 when the logged ops since base equal exp_ops; otherwise first bad index (-2: length)
    function automatic int ops_mismatch(input int base);
        if (op_q.size() - base != exp_ops.size()) return -2;
        foreach (exp_ops[i]) if (op_q[base + i] != exp_ops[i]) return i;
        return -1;
    endfunction

    // drive one command, collect its response after `hold` cycles of backpressure
    task automatic do_cmd(input bit s, input bit w, input bit r, input bit p, input bit n,
                          input logic [7:0] d, input int hold,
                          output logic [7:0] rd, output logic rn, output logic re,
                          output int lat, output int unstable, output bit ok);
        int k;
        ok = 1; unstable = 0; lat = 0; rd = 8'd0; rn = 1'b0; re = 1'b0;
        cmd_start = s; cmd_write = w; cmd_read = r; cmd_stop = p; cmd_nack = n;
        cmd_data = d; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin @(posedge clk); #1; k++; end
        if (!cmd_ready) ok = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (!rsp_valid && lat < 3000) begin @(posedge clk); #1; lat++; end
        if (!rsp_valid) begin ok = 0; return; end
        rd = rsp_data; rn = rsp_nack; re = rsp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_data !== rd || rsp_nack !== rn ||
                rsp_err !== re || cmd_ready !== 1'b0) unstable++;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) unstable++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        n_checks++;
        if ({phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus,
             rsp_valid, rsp_nack, rsp_err, rsp_data} !== 16'd0) begin
            n_fail++; $display("FAIL reset_outputs: got phy %b%b%b%b rel %b rsp %b/%h/%b/%b expected all 0",
                phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus,
                rsp_valid, rsp_data, rsp_nack, rsp_err);
        end
        rst = 1'b0; ref_bus = 0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write_ack;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm; bit ok;
        base = op_q.size();
        ref_cmd(1, 1, 0, 1, 0, 8'hA5, 1'b0, 8'h00);
        do_cmd(1, 1, 0, 1, 0, 8'hA5, 0, gd, gn, ge, lat, uns, ok);
        mm = ops_mismatch(base);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wr_ack_handshake: no response within bound"); end
        n_checks++;
        if (mm != -1) begin n_fail++; $display("FAIL wr_ack_ops: got %0d ops (bad idx %0d) expected %0d", op_q.size() - base, mm, exp_ops.size()); end
        n_checks++;
        if ({gn, ge} !== {exp_nack, exp_err}) begin n_fail++; $display("FAIL wr_ack_rsp: got nack %b err %b expected %b %b", gn, ge, exp_nack, exp_err); end
        n_checks++;
        if (phy_state !== 5'd0) begin n_fail++; $display("FAIL wr_ack_phy_idle: got %0d expected 0", phy_state); end
    endtask

    task automatic test_write_nack;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm; bit ok;
        base = op_q.size();
        ref_cmd(1, 1, 0, 0, 0, 8'h3C, 1'b1, 8'h00);
        do_cmd(1, 1, 0, 0, 0, 8'h3C, 0, gd, gn, ge, lat, uns, ok);
        mm = ops_mismatch(base);
        n_checks++;
        if (!ok || mm != -1) begin n_fail++; $display("FAIL wr_nack_ops: got ok %0d bad idx %0d expected ok 1 idx -1", ok, mm); end
        n_checks++;
        if ({gn, ge} !== {1'b1, 1'b0}) begin n_fail++; $display("FAIL wr_nack_rsp: got nack %b err %b expected 1 0", gn, ge); end
        base = op_q.size();
        ref_cmd(0, 1, 0, 0, 0, 8'h00, 1'b0, 8'h00);
        do_cmd(0, 1, 0, 0, 0, 8'h00, 0, gd, gn, ge, lat, uns, ok);
        mm = ops_mismatch(base);
        n_checks++;
        if (!ok || ge !== 1'b0 || gn !== 1'b0) begin n_fail++; $display("FAIL held_write_rsp: got ok %0d err %b nack %b expected 1 0 0", ok, ge, gn); end
        n_checks++;
        if (mm != -1) begin n_fail++; $display("FAIL held_write_ops: got bad idx %0d expected -1", mm); end
    endtask

    task automatic test_read;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm, op9; bit ok;
        base = op_q.size();
        ref_cmd(0, 0, 1, 1, 1, 8'h00, 1'b0, 8'h96);
        do_cmd(0, 0, 1, 1, 1, 8'h00, 0, gd, gn, ge, lat, uns, ok);
        mm  = ops_mismatch(base);
        op9 = (op_q.size() > base + 8) ? op_q[base + 8] : -1;
        n_checks++;
        if (!ok || gd !== 8'h96 || ge !== 1'b0) begin n_fail++; $display("FAIL read_data: got ok %0d data %h err %b expected 1 96 0", ok, gd, ge); end
        n_checks++;
        if (op9 != OP_W1) begin n_fail++; $display("FAIL read_ack_op: got op %0d expected %0d", op9, OP_W1); end
        n_checks++;
        if (mm != -1) begin n_fail++; $display("FAIL read_ops: got bad idx %0d expected -1", mm); end
    endtask

    task automatic test_illegal;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm; bit ok;
        logic [3:0] tbl [3];
        tbl[0] = 4'b1110; tbl[1] = 4'b0100; tbl[2] = 4'b0010;   // {start,write,read,stop}
        for (int i = 0; i < 3; i++) begin
            base = op_q.size();
            ref_cmd(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0], 0, 8'h55, 1'b0, 8'h00);
            do_cmd(tbl[i][3], tbl[i][2], tbl[i][1], tbl[i][0], 0, 8'h55, 0, gd, gn, ge, lat, uns, ok);
            mm = ops_mismatch(base);
            n_checks++;
            if (!ok || ge !== 1'b1 || lat > 2) begin n_fail++; $display("FAIL illegal_%0d_err: got ok %0d err %b lat %0d expected 1 1 <=2", i, ok, ge, lat); end
            n_checks++;
            if (mm != -1 || gd !== 8'd0 || gn !== 1'b0) begin n_fail++; $display("FAIL illegal_%0d_quiet: got %0d ops data %h nack %b expected 0 ops 00 0", i, op_q.size() - base, gd, gn); end
        end
    endtask

    task automatic test_empty;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm; bit ok;
        for (int i = 0; i < 2; i++) begin
            base = op_q.size();
            ref_cmd(0, 0, 0, i[0], 0, 8'hFF, 1'b0, 8'h00);
            do_cmd(0, 0, 0, i[0], 0, 8'hFF, 0, gd, gn, ge, lat, uns, ok);
            mm = ops_mismatch(base);
            n_checks++;
            if (!ok || mm != -1 || {gd, gn, ge} !== 10'd0) begin n_fail++; $display("FAIL empty_%0d: got ok %0d idx %0d rsp %h/%b/%b expected 1 -1 00/0/0", i, ok, mm, gd, gn, ge); end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] gd; logic gn, ge; int lat, uns, base, mm; bit ok;
        base = op_q.size();
        ref_cmd(1, 1, 0, 1, 0, 8'h5A, 1'b1, 8'h00);
        do_cmd(1, 1, 0, 1, 0, 8'h5A, 20, gd, gn, ge, lat, uns, ok);
        mm = ops_mismatch(base);
        n_checks++;
        if (!ok || uns != 0) begin n_fail++; $display("FAIL backpressure_stable: got ok %0d unstable %0d expected 1 0", ok, uns); end
        n_checks++;
        if (mm != -1 || gn !== exp_nack || ge !== 1'b0) begin n_fail++; $display("FAIL backpressure_rsp: got idx %0d nack %b err %b expected -1 %b 0", mm, gn, ge, exp_nack); end
    endtask

    task automatic test_random;
        logic [7:0] gd, d, sb; logic gn, ge; int lat, uns, base, mm, mode, hold; bit ok, s, w, r, p, n, ack;
        for (int it = 0; it < 24; it++) begin
            mode = $urandom_range(0, 9);
            w = (mode == 0) || (mode >= 1 && mode <= 4);
            r = (mode == 0) || (mode >= 5 && mode <= 8);
            s = ($urandom_range(0, 3) != 0);
            p = $urandom_range(0, 1);
            n = $urandom_range(0, 1);
            ack = $urandom_range(0, 1);
            d  = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            hold = $urandom_range(0, 3);
            base = op_q.size();
            ref_cmd(s, w, r, p, n, d, ack, sb);
            do_cmd(s, w, r, p, n, d, hold, gd, gn, ge, lat, uns, ok);
            mm = ops_mismatch(base);
            n_checks++;
            if (!ok || mm != -1) begin n_fail++; $display("FAIL rand_%0d_ops: got ok %0d idx %0d (%0d ops) expected 1 -1 (%0d ops)", it, ok, mm, op_q.size() - base, exp_ops.size()); end
            n_checks++;
            if (gd !== exp_data) begin n_fail++; $display("FAIL rand_%0d_data: got %h expected %h", it, gd, exp_data); end
            n_checks++;
            if ({gn, ge} !== {exp_nack, exp_err}) begin n_fail++; $display("FAIL rand_%0d_flags: got nack %b err %b expected %b %b", it, gn, ge, exp_nack, exp_err); end
            n_checks++;
            if (uns != 0) begin n_fail++; $display("FAIL rand_%0d_hold: got %0d unstable expected 0", it, uns); end
        end
    endtask

    task automatic test_reset_mid;
        int k;
        cmd_start = 1; cmd_write = 1; cmd_read = 0; cmd_stop = 1; cmd_nack = 0;
        cmd_data = 8'hFF; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        while (!phy_write_bit && k < 200) begin @(posedge clk); #1; k++; end
        n_checks++;
        if (!phy_write_bit) begin n_fail++; $display("FAIL reset_mid_reach: got no write_bit expected one within 200 cycles"); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({cmd_ready, phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, phy_release_bus,
             rsp_valid, rsp_nack, rsp_err, rsp_data} !== 17'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got ready %b phy %b%b%b%b rsp %b/%h expected all 0",
                cmd_ready, phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit, rsp_valid, rsp_data);
        end
        rst = 1'b0; ref_bus = 0;
        @(posedge clk); #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_timeout;
`ifdef I2C_CTRL_TIMEOUT_EN
        int k;
        stuck = 1;
        cmd_start = 1; cmd_write = 1; cmd_read = 0; cmd_stop = 1; cmd_nack = 0;
        cmd_data = 8'h11; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n_checks++;
        if (phy_start_bit !== 1'b1) begin n_fail++; $display("FAIL timeout_issue: got start %b expected 1", phy_start_bit); end
        k = 0;
        while (!phy_release_bus && k < 300) begin @(posedge clk); #1; k++; end
        n_checks++;
        if (k != 100) begin n_fail++; $display("FAIL timeout_cycle: got release at %0d expected 100", k); end
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'd0 ||
            {phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit} !== 4'd0) begin
            n_fail++; $display("FAIL timeout_rsp: got valid %b err %b data %h reqs %b%b%b%b expected 1 1 00 0000",
                rsp_valid, rsp_err, rsp_data, phy_start_bit, phy_stop_bit, phy_write_bit, phy_read_bit);
        end
        @(posedge clk); #1;
        n_checks++;
        if (phy_release_bus !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 0", phy_release_bus); end
        stuck = 0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        ref_bus = 0;
`else
        n_checks++;
        if (rel_seen != 0) begin n_fail++; $display("FAIL release_tied: got %0d pulses expected 0", rel_seen); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_write_nack();
        test_read();
        test_illegal();
        test_empty();
        test_backpressure();
        test_random();
        test_timeout();
        test_reset_mid();
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL phy_protocol: got %0d request violations expected 0", viol); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected finish before 50000 cycles");
        $fatal(1, "bench time limit");
    end
endmodule
